life_engine: RTL and testbench



---
 rtl/life_pkg.sv | 23 ++
 rtl/life_row_rule.sv | 26 ++
 rtl/life_engine.sv | 124 ++++++++++++
 tb/tb_life_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, defaults and wrap helpers for the life engine
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 8;

    // Toroidal predecessor of index i in a ring of n entries.
    function automatic int wrap_dec(input int i, input int n);
        return (i == 0) ? n - 1 : i - 1;
    endfunction

    // Toroidal successor of index i in a ring of n entries.
    function automatic int wrap_inc(input int i, input int n);
        return (i == n - 1) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/life_row_rule.sv
// rtl/life_row_rule.sv - next-generation rule for one row from its three-row neighbourhood
module life_row_rule
    import life_pkg::*;
#(
    parameter int COLS = COLS_DEF
) (
    input  logic [COLS-1:0] above_i,
    input  logic [COLS-1:0] cur_i,
    input  logic [COLS-1:0] below_i,
    output logic [COLS-1:0] next_o
);

    // Column neighbours are resolved at elaboration, so every index is constant.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int L = wrap_dec(c, COLS);
        localparam int R = wrap_inc(c, COLS);
        logic [3:0] n;

        assign n = 4'(above_i[L]) + 4'(above_i[c]) + 4'(above_i[R])
                 + 4'(cur_i[L])                    + 4'(cur_i[R])
                 + 4'(below_i[L]) + 4'(below_i[c]) + 4'(below_i[R]);

        assign next_o[c] = (n == 4'd3) | (cur_i[c] & (n == 4'd2));
    end

endmodule

// File: rtl/life_engine.sv
// rtl/life_engine.sv - Game of Life board with row-per-clock generation stepping
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int GEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_i,
    input  logic                    run_i,
    input  logic                    load_i,
    input  logic [$clog2(ROWS)-1:0] load_row_i,
    input  logic [COLS-1:0]         load_data_i,
    output logic [ROWS*COLS-1:0]    board_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    missed_o,
    output logic [GEN_W-1:0]        gen_count_o
);

    localparam int RW = $clog2(ROWS);

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] board_q  [ROWS];
    logic [COLS-1:0] shadow_q [ROWS];
    logic [GEN_W-1:0] gen_q;
    logic            done_q;
    logic            missed_q;

    logic [RW-1:0]   row_up, row_dn;
    logic [COLS-1:0] next_row;

    logic tick_acc;
    assign tick_acc = tick_i & run_i;

    // Neighbour rows always come from the visible board, never the shadow.
    always_comb begin
        row_up = RW'(wrap_dec(int'(row_q), ROWS));
        row_dn = RW'(wrap_inc(int'(row_q), ROWS));
    end

    life_row_rule #(.COLS(COLS)) u_rule (
        .above_i (board_q[row_up]),
        .cur_i   (board_q[row_q]),
        .below_i (board_q[row_dn]),
        .next_o  (next_row)
    );

    // State and row-index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic; a simultaneous load suppresses the tick.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tick_acc && !load_i) begin
                    state_d = ST_COMPUTE;
                    row_d   = '0;
                end
            end
            ST_COMPUTE: begin
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Board, shadow, counter and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                board_q[r]  <= '0;
                shadow_q[r] <= '0;
            end
            gen_q    <= '0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            done_q   <= (state_q == ST_COMMIT);
            missed_q <= tick_acc && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (load_i && (32'(load_row_i) < ROWS)) begin
                        board_q[load_row_i] <= load_data_i;
                    end
                end
                ST_COMPUTE: shadow_q[row_q] <= next_row;
                ST_COMMIT: begin
                    board_q <= shadow_q;
                    gen_q   <= gen_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_flat
        assign board_o[r*COLS +: COLS] = board_q[r];
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign missed_o    = missed_q;
    assign gen_count_o = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// tb/tb_life_engine.sv - self-checking bench for life_engine against a grid model
module tb_life_engine;

    localparam int R = 8;
    localparam int C = 8;
    localparam int G = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          run = 1'b0;
    logic          load = 1'b0;
    logic [2:0]    load_row = '0;
    logic [C-1:0]  load_data = '0;
    logic [R*C-1:0] board;
    logic          busy, done, missed;
    logic [G-1:0]  gen_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_seen = 0;
    int missed_seen = 0;

    logic [63:0] exp_board = '0;
    logic [G-1:0] exp_gen = '0;
    logic        exp_done = 1'b0;
    logic        exp_missed = 1'b0;
    int          remain = 0;

    life_engine #(.ROWS(R), .COLS(C), .GEN_W(G)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick),
        .run_i       (run),
        .load_i      (load),
        .load_row_i  (load_row),
        .load_data_i (load_data),
        .board_o     (board),
        .busy_o      (busy),
        .done_o      (done),
        .missed_o    (missed),
        .gen_count_o (gen_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Next generation on a torus, straight from the rules.
    function automatic logic [63:0] life_step(input logic [63:0] b);
        logic [63:0] nb;
        int n;
        nb = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(b[((r + dr + R) % R) * C + ((c + dc + C) % C)]);
                nb[r*C + c] = (n == 3) || (b[r*C + c] && n == 2);
            end
        end
        return nb;
    endfunction

    // Model: a generation takes ROWS+1 clocks after the accepting edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_board = '0; exp_gen = '0; remain = 0;
            exp_done = 1'b0; exp_missed = 1'b0;
        end else begin
            exp_done = 1'b0;
            exp_missed = 1'b0;
            if (remain > 0) begin
                if (tick && run) exp_missed = 1'b1;
                remain--;
                if (remain == 0) begin
                    exp_board = life_step(exp_board);
                    exp_gen = exp_gen + 1'b1;
                    exp_done = 1'b1;
                end
            end else if (load) begin
                exp_board[load_row*C +: C] = load_data;
            end else if (tick && run) begin
                remain = R + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("board", board, exp_board);
            check("gen_count", 64'(gen_count), 64'(exp_gen));
            check("busy", 64'(busy), 64'(remain > 0));
            check("done", 64'(done), 64'(exp_done));
            check("missed", 64'(missed), 64'(exp_missed));
            if (done) done_seen++;
            if (missed) missed_seen++;
        end
    end

    task automatic load_row_task(input int r, input logic [C-1:0] d);
        load = 1'b1; load_row = 3'(r); load_data = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic clear_board();
        for (int r = 0; r < R; r++) load_row_task(r, '0);
    endtask

    task automatic do_tick();
        int k;
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        k = 0;
        while (k < 20 && !done) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", 64'(k), 64'd9);
        @(negedge clk);
    endtask

    initial begin
        int m0, d0;
        repeat (2) @(negedge clk);
        check("rst_board", board, 64'h0);
        check("rst_gen", 64'(gen_count), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_missed", 64'(missed), 64'h0);
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);

        // Blinker
        load_row_task(3, 8'b0001_1100);
        check("blinker_load", board, 64'h0000_0000_1C00_0000);
        do_tick();
        check("blinker_v", board, 64'h0000_0008_0808_0000);
        do_tick();
        check("blinker_h", board, 64'h0000_0000_1C00_0000);
        check("blinker_gen", 64'(gen_count), 64'd2);

        // Second tick three cycles after an accepted one
        m0 = missed_seen;
        tick = 1'b1; @(posedge clk); @(negedge clk); tick = 1'b0;
        @(negedge clk); @(negedge clk);
        tick = 1'b1; @(posedge clk); @(negedge clk); tick = 1'b0;
        repeat (12) @(negedge clk);
        check("collide_board", board, 64'h0000_0008_0808_0000);
        check("collide_gen", 64'(gen_count), 64'd3);
        check("collide_missed", 64'(missed_seen - m0), 64'd1);

        // Load while busy is dropped
        tick = 1'b1; @(posedge clk); @(negedge clk); tick = 1'b0;
        @(negedge clk);
        load_row_task(0, 8'hFF);
        repeat (12) @(negedge clk);
        check("busy_load_board", board, 64'h0000_0000_1C00_0000);
        check("busy_load_gen", 64'(gen_count), 64'd4);

        // Pause
        run = 1'b0;
        repeat (2) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("pause_board", board, 64'h0000_0000_1C00_0000);
        check("pause_gen", 64'(gen_count), 64'd4);
        run = 1'b1;

        // Load and tick in the same cycle
        tick = 1'b1;
        load_row_task(0, 8'h03);
        tick = 1'b0;
        repeat (12) @(negedge clk);
        check("prec_board", board, 64'h0000_0000_1C00_0003);
        check("prec_gen", 64'(gen_count), 64'd4);

        // Block still life
        clear_board();
        load_row_task(0, 8'h03);
        load_row_task(1, 8'h03);
        repeat (5) do_tick();
        check("block_board", board, 64'h0000_0000_0000_0303);
        check("block_gen", 64'(gen_count), 64'd9);

        // Glider across the torus
        clear_board();
        load_row_task(5, 8'h40);
        load_row_task(6, 8'h80);
        load_row_task(7, 8'hE0);
        check("glider_start", board, 64'hE080_4000_0000_0000);
        repeat (32) do_tick();
        check("glider_wrap", board, 64'hE080_4000_0000_0000);
        check("glider_gen", 64'(gen_count), 64'd41);

        // Reset in the middle of a generation
        d0 = done_seen;
        tick = 1'b1; @(posedge clk); @(negedge clk); tick = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_board", board, 64'h0);
        check("midrst_gen", 64'(gen_count), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_no_done", 64'(done_seen - d0), 64'd0);
        check("midrst_gen_after", 64'(gen_count), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
